// File: rtl/blink_pkg.sv
// Shared definitions for the blinker family (programmable_blinker and
// blink_rate_sequencer).
//  - state_e        : sequencer FSM state encoding
//  - RATE_W_DEFAULT : default width of the blinker one-hot rate register
//  - idx_w()        : width of a binary index into an N-wide one-hot register
package blink_pkg;

  localparam int unsigned RATE_W_DEFAULT = 4;

  // Sequencer states: M* are manual (button driven), S* are autonomous sweep.
  typedef enum logic [2:0] {
    MIdle   = 3'd0,
    MHold   = 3'd1,
    MRepeat = 3'd2,
    SUp     = 3'd3,
    SDown   = 3'd4
  } state_e;

  // Index width for an N-entry one-hot; never less than 1 so RATE_W=1 still
  // yields a legal port.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/blink_beat_timer.sv
// Beat timer: counts count_en pulses and flags the beat on which the count
// reaches a runtime limit, wrapping to 0 in that same cycle.
// Ports:
//  clk, rst  clock, async active-high reset
//  count_en  beat tick; only these cycles advance the count
//  clear     force count to 0; a beat in the same cycle is not counted
//  limit     number of beats per period (>= 1)
//  expired   high in the cycle of the limit-th beat
module blink_beat_timer #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         count_en,
  input  logic         clear,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  // Does not depend on clear, so callers may derive clear from expired.
  assign expired = count_en & (cnt_q == (limit - W'(1)));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en) begin
      cnt_d = expired ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/blink_rate_sequencer.sv
// Blink rate sequencer: converts synchronised push-button levels into
// single-cycle shift_left/shift_right pulses for programmable_blinker, with
// hold-to-repeat, plus an autonomous sweep mode that walks the rate up and
// down on a beat-paced schedule.
// Ports:
//  clk, rst     clock, async active-high reset
//  count_en     beat tick shared with the blinkers
//  btn_left     held level; requests shift_left (rate_idx + 1)
//  btn_right    held level; requests shift_right (rate_idx - 1)
//  btn_mode     held level; each rising edge toggles manual/sweep
//  shift_left   1-cycle pulse to blinker(s)
//  shift_right  1-cycle pulse to blinker(s)
//  rate_idx     shadow of the blinker one-hot position
//  sweep_mode   1 while sweep is active
module blink_rate_sequencer
  import blink_pkg::*;
#(
  parameter int unsigned RATE_W       = RATE_W_DEFAULT,
  parameter int unsigned HOLD_BEATS   = 16,
  parameter int unsigned REPEAT_BEATS = 4,
  parameter int unsigned STEP_BEATS   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      count_en,
  input  logic                      btn_left,
  input  logic                      btn_right,
  input  logic                      btn_mode,
  output logic                      shift_left,
  output logic                      shift_right,
  output logic [idx_w(RATE_W)-1:0]  rate_idx,
  output logic                      sweep_mode
);

  localparam int unsigned IdxW     = idx_w(RATE_W);
  localparam int unsigned MaxBeats0 = (HOLD_BEATS > REPEAT_BEATS) ? HOLD_BEATS : REPEAT_BEATS;
  localparam int unsigned MaxBeats = (MaxBeats0 > STEP_BEATS) ? MaxBeats0 : STEP_BEATS;
  localparam int unsigned TimerW   = $clog2(MaxBeats + 1);
  localparam logic [IdxW-1:0] MaxIdx = IdxW'(RATE_W - 1);

  state_e          state_q, state_d;
  logic            dir_q, dir_d;  // held button in M_HOLD/M_REPEAT: 0 left, 1 right
  logic            prev_l_q, prev_r_q, prev_m_q;
  logic            sl_q, sl_d, sr_q, sr_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            sweep_q, sweep_d;

  logic              rise_l, rise_r, rise_m;
  logic              conflict, held;
  logic              can_up, can_down;
  logic              req_left, req_right;
  logic              timer_clear, timer_expired;
  logic [TimerW-1:0] timer_limit;

  assign rise_l = btn_left & ~prev_l_q;
  assign rise_r = btn_right & ~prev_r_q;
  assign rise_m = btn_mode & ~prev_m_q;

  // Opposing requests cancel: both rise together, or one rises while the other is held.
  assign conflict = (rise_l & (rise_r | btn_right)) | (rise_r & btn_left);
  assign held     = dir_q ? btn_right : btn_left;
  assign can_up   = (idx_q != MaxIdx);
  assign can_down = (idx_q != '0);

  always_comb begin
    timer_limit = TimerW'(HOLD_BEATS);
    unique case (state_q)
      MRepeat:   timer_limit = TimerW'(REPEAT_BEATS);
      SUp, SDown: timer_limit = TimerW'(STEP_BEATS);
      default:   timer_limit = TimerW'(HOLD_BEATS);
    endcase
  end

  blink_beat_timer #(
    .W (TimerW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .count_en (count_en),
    .clear    (timer_clear),
    .limit    (timer_limit),
    .expired  (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    sweep_d     = sweep_q;
    idx_d       = idx_q;
    sl_d        = 1'b0;
    sr_d        = 1'b0;
    timer_clear = 1'b0;
    req_left    = 1'b0;
    req_right   = 1'b0;

    if (rise_m) begin
      // Mode toggle outranks any left/right activity this cycle.
      timer_clear = 1'b1;
      if (state_q inside {SUp, SDown}) begin
        sweep_d = 1'b0;
        state_d = MIdle;
      end else begin
        sweep_d = 1'b1;
        state_d = can_up ? SUp : SDown;
      end
    end else begin
      unique case (state_q)
        MIdle, MHold, MRepeat: begin
          if (rise_l | rise_r) begin
            // A fresh press always restarts the hold sequence.
            if (conflict) begin
              state_d = MIdle;
            end else begin
              timer_clear = 1'b1;
              state_d     = MHold;
              dir_d       = rise_r;
              req_left    = rise_l;
              req_right   = rise_r;
            end
          end else if (state_q != MIdle) begin
            if (!held) begin
              state_d = MIdle;
            end else if (timer_expired) begin
              req_left  = ~dir_q;
              req_right = dir_q;
              if (state_q == MHold) begin
                timer_clear = 1'b1;
                state_d     = MRepeat;
              end
            end
          end
        end
        SUp: begin
          if (timer_expired) begin
            req_left = 1'b1;
            if (idx_q == MaxIdx - IdxW'(1)) begin
              state_d = SDown;
            end
          end
        end
        SDown: begin
          if (timer_expired) begin
            req_right = 1'b1;
            if (idx_q == IdxW'(1)) begin
              state_d = SUp;
            end
          end
        end
        default: state_d = MIdle;
      endcase
    end

    // Requests past either end of the rate range are dropped silently.
    if (req_left && can_up) begin
      sl_d  = 1'b1;
      idx_d = idx_q + IdxW'(1);
    end else if (req_right && can_down) begin
      sr_d  = 1'b1;
      idx_d = idx_q - IdxW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MIdle;
      dir_q    <= 1'b0;
      prev_l_q <= 1'b0;
      prev_r_q <= 1'b0;
      prev_m_q <= 1'b0;
      sl_q     <= 1'b0;
      sr_q     <= 1'b0;
      idx_q    <= '0;
      sweep_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      prev_l_q <= btn_left;
      prev_r_q <= btn_right;
      prev_m_q <= btn_mode;
      sl_q     <= sl_d;
      sr_q     <= sr_d;
      idx_q    <= idx_d;
      sweep_q  <= sweep_d;
    end
  end

  assign shift_left  = sl_q;
  assign shift_right = sr_q;
  assign rate_idx    = idx_q;
  assign sweep_mode  = sweep_q;

endmodule

// File: tb/tb_blink_rate_sequencer.sv
module tb_blink_rate_sequencer;

  localparam int MAXI = 3;
  localparam int HOLD = 16;
  localparam int REP  = 4;
  localparam int STEP = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       count_en;
  logic       btn_left, btn_right, btn_mode;
  logic       shift_left, shift_right, sweep_mode;
  logic [1:0] rate_idx;
  logic [4:0] dut_vec;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the outputs must be after the latest edge.
  logic m_sl, m_sr, m_sweep, m_up;
  logic m_pl, m_pr, m_pm;
  int   m_idx;
  int   m_held;    // 0 none, 1 left, 2 right
  int   m_beats;   // beats since the current press
  int   m_sbeats;  // beats since sweep entry

  blink_rate_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .count_en    (count_en),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_mode    (btn_mode),
    .shift_left  (shift_left),
    .shift_right (shift_right),
    .rate_idx    (rate_idx),
    .sweep_mode  (sweep_mode)
  );

  always #5 clk = ~clk;

  assign dut_vec = {shift_left, shift_right, rate_idx, sweep_mode};

  function automatic logic [4:0] exp_vec();
    return {m_sl, m_sr, 2'(m_idx), m_sweep};
  endfunction

  task automatic model_reset();
    m_sl = 0; m_sr = 0; m_sweep = 0; m_up = 0;
    m_pl = 0; m_pr = 0; m_pm = 0;
    m_idx = 0; m_held = 0; m_beats = 0; m_sbeats = 0;
  endtask

  task automatic model_pulse(input int dir);
    if (dir == 1 && m_idx < MAXI) begin
      m_idx++;
      m_sl = 1;
    end else if (dir == 2 && m_idx > 0) begin
      m_idx--;
      m_sr = 1;
    end
  endtask

  task automatic model_step(input logic l, input logic r, input logic m, input logic ce);
    logic rl, rr, rm;
    rl = l & ~m_pl;
    rr = r & ~m_pr;
    rm = m & ~m_pm;
    m_sl = 0;
    m_sr = 0;
    if (rm) begin
      if (!m_sweep) begin
        m_sweep  = 1;
        m_up     = (m_idx < MAXI);
        m_sbeats = 0;
      end else begin
        m_sweep = 0;
      end
      m_held = 0;
    end else if (m_sweep) begin
      if (ce) begin
        m_sbeats++;
        if (m_sbeats % STEP == 0) begin
          if (m_up) begin
            model_pulse(1);
            if (m_idx == MAXI) m_up = 0;
          end else begin
            model_pulse(2);
            if (m_idx == 0) m_up = 1;
          end
        end
      end
    end else if (rl || rr) begin
      if ((rl && (rr || r)) || (rr && l)) begin
        m_held = 0;
      end else begin
        m_held  = rl ? 1 : 2;
        m_beats = 0;
        model_pulse(m_held);
      end
    end else if (m_held != 0) begin
      if ((m_held == 1 && !l) || (m_held == 2 && !r)) begin
        m_held = 0;
      end else if (ce) begin
        m_beats++;
        if (m_beats == HOLD || (m_beats > HOLD && (m_beats - HOLD) % REP == 0))
          model_pulse(m_held);
      end
    end
    m_pl = l;
    m_pr = r;
    m_pm = m;
  endtask

  // One clock: model follows the inputs the DUT samples, outputs settle by +1.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step(btn_left, btn_right, btn_mode, count_en);
    #1;
    count_en = ~count_en;
  endtask

  task automatic test_reset();
    int pulses;
    pulses = 0;
    rst = 1; btn_left = 0; btn_right = 0; btn_mode = 0; count_en = 0;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== 5'b0) begin
      errors++;
      $display("FAIL reset_async got %b exp %b", dut_vec, 5'b0);
    end
    repeat (3) tick();
    rst = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      pulses += shift_left + shift_right;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL reset_idle cyc %0d got %b exp %b", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_no_pulse got %0d exp 0", pulses);
    end
  endtask

  task automatic test_left_taps();
    int pulses;
    for (int k = 0; k < 4; k++) begin
      pulses = 0;
      btn_left = 1;
      for (int i = 0; i < $urandom_range(24, 8); i++) begin
        tick();
        pulses += shift_left;
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++;
          $display("FAIL tap%0d cyc %0d got %b exp %b", k, i, dut_vec, exp_vec());
        end
      end
      btn_left = 0;
      for (int i = 0; i < $urandom_range(20, 10); i++) begin
        tick();
        pulses += shift_left;
      end
      checks++;
      if (pulses != ((k < 3) ? 1 : 0)) begin
        errors++;
        $display("FAIL tap%0d_pulses got %0d exp %0d", k, pulses, (k < 3) ? 1 : 0);
      end
    end
    checks++;
    if (rate_idx !== 2'd3) begin
      errors++;
      $display("FAIL taps_rate got %0d exp 3", rate_idx);
    end
  endtask

  task automatic test_hold_repeat();
    int pulses;
    pulses = 0;
    btn_right = 1;
    for (int i = 0; i < 200; i++) begin
      tick();
      pulses += shift_right;
      checks++;
      if (dut_vec !== exp_vec() || (shift_left & shift_right)) begin
        errors++;
        $display("FAIL hold cyc %0d got %b exp %b", i, dut_vec, exp_vec());
      end
    end
    btn_right = 0;
    repeat (6) tick();
    checks++;
    if (pulses != 3 || rate_idx !== 2'd0) begin
      errors++;
      $display("FAIL hold_total got %0d/%0d exp 3/0", pulses, rate_idx);
    end
  endtask

  task automatic test_both_rise();
    int pulses;
    pulses = 0;
    btn_left = 1; repeat (6) tick();
    btn_left = 0; repeat (6) tick();
    btn_left = 1; btn_right = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      pulses += shift_left + shift_right;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL both cyc %0d got %b exp %b", i, dut_vec, exp_vec());
      end
    end
    btn_left = 0; btn_right = 0;
    repeat (6) tick();
    checks++;
    if (pulses != 0 || rate_idx !== 2'd1) begin
      errors++;
      $display("FAIL both_total got %0d/%0d exp 0/1", pulses, rate_idx);
    end
  endtask

  task automatic test_sweep();
    int nl, nr;
    nl = 0; nr = 0;
    btn_right = 1; repeat (6) tick();
    btn_right = 0; repeat (6) tick();
    btn_mode = 1; repeat (4) tick();
    btn_mode = 0;
    for (int i = 0; i < 480; i++) begin
      if ($urandom_range(15, 0) == 0) btn_left = ~btn_left;
      tick();
      nl += shift_left;
      nr += shift_right;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL sweep cyc %0d got %b exp %b", i, dut_vec, exp_vec());
      end
    end
    btn_left = 0;
    checks++;
    if (nl != 4 || nr != 3 || rate_idx !== 2'd1 || sweep_mode !== 1'b1) begin
      errors++;
      $display("FAIL sweep_total got l%0d r%0d idx%0d m%0d exp l4 r3 idx1 m1",
               nl, nr, rate_idx, sweep_mode);
    end
    btn_mode = 1; repeat (4) tick();
    btn_mode = 0;
    nl = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      nl += shift_left + shift_right;
    end
    checks++;
    if (nl != 0 || rate_idx !== 2'd1 || sweep_mode !== 1'b0) begin
      errors++;
      $display("FAIL sweep_exit got p%0d idx%0d m%0d exp p0 idx1 m0", nl, rate_idx, sweep_mode);
    end
  endtask

  task automatic test_async_reset();
    int pulses;
    for (int phase = 0; phase < 2; phase++) begin
      if (phase == 0) begin
        btn_left = 1;
        repeat (50) tick();
      end else begin
        btn_mode = 1; repeat (4) tick();
        btn_mode = 0; repeat (226) tick();
      end
      #2;
      rst = 1;
      model_reset();
      #1;
      checks++;
      if (dut_vec !== 5'b0) begin
        errors++;
        $display("FAIL async_rst%0d got %b exp %b", phase, dut_vec, 5'b0);
      end
      btn_left = 0;
      repeat (3) tick();
      rst = 0;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
        tick();
        pulses += shift_left + shift_right;
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++;
          $display("FAIL post_rst%0d cyc %0d got %b exp %b", phase, i, dut_vec, exp_vec());
        end
      end
      checks++;
      if (pulses != 0) begin
        errors++;
        $display("FAIL post_rst%0d_pulses got %0d exp 0", phase, pulses);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(11, 0) == 0) btn_left = ~btn_left;
      if ($urandom_range(11, 0) == 0) btn_right = ~btn_right;
      if ($urandom_range(59, 0) == 0) btn_mode = ~btn_mode;
      tick();
      checks++;
      if (dut_vec !== exp_vec() || (shift_left & shift_right)) begin
        errors++;
        $display("FAIL random cyc %0d got %b exp %b", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_left_taps();
    test_hold_repeat();
    test_both_rise();
    test_sweep();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
